tz_stream_counter: RTL and testbench

- Streaming trailing-zero counter. Counts trailing zeros, or trailing ones, across a multi-beat packet; beat 0 holds the least-significant word.
- Parametrised, registered successor of the single-word combinational trailing-zero counter.
- Valid/ready on both sides. One result per packet, held in a one-entry output register.
- Sits between packet-oriented datapaths and normalisation, priority or scheduling logic.

---
 rtl/tz_stream_counter.sv | 99 +++++++++
 tb/tb_tz_stream_counter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tz_stream_counter.sv
// tz_stream_counter: streaming trailing-zero/one counter across multi-beat packets, one registered result per packet.
// Define TZC_PKT_STATS_EN to add the saturating completed-packet counter m_pkt_cnt.
module tz_stream_counter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int CNT_W      = $clog2(DATA_WIDTH*MAX_BEATS+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_ones,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      m_count,
    output logic                  m_all,
    output logic                  m_overflow
`ifdef TZC_PKT_STATS_EN
    ,
    output logic [15:0]           m_pkt_cnt
`endif
);
    localparam int TZ_W  = $clog2(DATA_WIDTH+1);
    localparam int IDX_W = $clog2(MAX_BEATS+1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_BEATS);
    localparam logic [0:0] FIRST = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      acc, acc_n;
    logic [IDX_W-1:0]      beat_idx;
    logic [DATA_WIDTH-1:0] w;
    logic [TZ_W-1:0]       tz;
    logic                  found, found_n, ovf, ovf_n, mode, eff_mode, fire, in_range, counting;

    assign s_ready  = !m_valid || m_ready;
    assign fire     = s_valid && s_ready;
    assign eff_mode = (state == FIRST) ? s_ones : mode;
    assign w        = eff_mode ? ~s_data : s_data;
    assign in_range = beat_idx < IDX_MAX;
    assign counting = in_range && !found;
    assign acc_n    = counting ? acc + CNT_W'(tz) : acc;
    assign found_n  = found || (counting && |w);
    assign ovf_n    = ovf || !in_range;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        tz = TZ_W'(DATA_WIDTH);
        for (int i = DATA_WIDTH-1; i >= 0; i--)
            if (w[i]) tz = TZ_W'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FIRST;
            acc        <= '0;
            found      <= 1'b0;
            ovf        <= 1'b0;
            beat_idx   <= '0;
            mode       <= 1'b0;
            m_valid    <= 1'b0;
            m_count    <= '0;
            m_all      <= 1'b0;
            m_overflow <= 1'b0;
        end else begin
            if (fire && state == FIRST) mode <= s_ones;
            if (fire && s_last) begin
                state    <= FIRST;
                acc      <= '0;
                found    <= 1'b0;
                ovf      <= 1'b0;
                beat_idx <= '0;
            end else if (fire) begin
                state    <= ACCUM;
                acc      <= acc_n;
                found    <= found_n;
                ovf      <= ovf_n;
                beat_idx <= in_range ? beat_idx + 1'b1 : IDX_MAX;
            end
            if (fire && s_last) begin
                m_valid    <= 1'b1;
                m_count    <= acc_n;
                m_all      <= !found_n;
                m_overflow <= ovf_n;
            end else if (m_ready) begin
                m_valid    <= 1'b0;
            end
        end
    end

`ifdef TZC_PKT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) m_pkt_cnt <= '0;
        else if (fire && s_last && m_pkt_cnt != 16'hFFFF) m_pkt_cnt <= m_pkt_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tz_stream_counter.sv
// tb_tz_stream_counter: directed and randomized checks of tz_stream_counter against a packet-level bit-scan model.
module tb_tz_stream_counter;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int CW = $clog2(DW*MB+1);

    logic clk = 0, reset = 1, s_valid = 0, s_last = 0, s_ones = 0, m_ready = 1;
    logic [DW-1:0] s_data = '0;
    logic s_ready, m_valid, m_all, m_overflow;
    logic [CW-1:0] m_count;
`ifdef TZC_PKT_STATS_EN
    logic [15:0] m_pkt_cnt;
`endif
    int tests = 0, fails = 0;
    bit rnd_rdy = 0;

    always #5 clk = ~clk;

    tz_stream_counter #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_ones(s_ones),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .m_all(m_all), .m_overflow(m_overflow)
`ifdef TZC_PKT_STATS_EN
        , .m_pkt_cnt(m_pkt_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Packet-level model: result register contents and the beats of the packet in progress.
    bit exp_valid = 0, exp_all = 0, exp_ovf = 0, pmode = 0;
    int exp_count = 0, pkts = 0, n_cnt;
    logic [DW-1:0] q[$];

    always @(negedge clk) begin
        chk("m_valid", m_valid, exp_valid);
        chk("s_ready", s_ready, !exp_valid || m_ready);
        if (exp_valid) begin
            chk("m_count", m_count, exp_count);
            chk("m_all", m_all, exp_all);
            chk("m_overflow", m_overflow, exp_ovf);
        end
`ifdef TZC_PKT_STATS_EN
        chk("m_pkt_cnt", m_pkt_cnt, pkts);
`endif
        if (reset) begin
            exp_valid = 0;
            q.delete();
            pkts = 0;
        end else if (s_valid && (!exp_valid || m_ready) && s_last) begin
            if (q.size() == 0) pmode = s_ones;
            q.push_back(s_data);
            n_cnt = (q.size() < MB) ? q.size() : MB;
            exp_count = DW * n_cnt;
            exp_all = 1;
            exp_ovf = q.size() > MB;
            for (int b = 0; b < n_cnt && exp_all; b++)
                for (int i = 0; i < DW && exp_all; i++)
                    if (q[b][i] ^ pmode) begin
                        exp_count = b*DW + i;
                        exp_all = 0;
                    end
            exp_valid = 1;
            q.delete();
            if (pkts < 16'hFFFF) pkts++;
        end else begin
            if (s_valid && (!exp_valid || m_ready)) begin
                if (q.size() == 0) pmode = s_ones;
                q.push_back(s_data);
            end
            if (m_ready) exp_valid = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd_rdy) m_ready = 1'($urandom % 2);
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l, input logic o);
        int n = 0;
        s_valid = 1; s_data = d; s_last = l; s_ones = o;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            @(posedge clk); #1;
            if (rnd_rdy) m_ready = 1'($urandom % 2);
            n++;
            if (n > 500) begin
                fails++;
                $display("FAIL handshake_timeout: s_ready stuck 0");
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1);
            end
        end
        @(posedge clk); #1;
        s_valid = 0; s_data = $urandom; s_last = 1'($urandom % 2); s_ones = 1'($urandom % 2);
        if (rnd_rdy) m_ready = 1'($urandom % 2);
    endtask

    initial begin
        logic [DW-1:0] d;
        int len;
        bit md;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_valid", m_valid, 0);
        chk("rst_count", m_count, 0);
        chk("rst_all", m_all, 0);
        chk("rst_ovf", m_overflow, 0);

        beat(32'h0000_0100, 1, 0);
        chk("t1_valid", m_valid, 1);
        chk("t1_count", m_count, 8);
        chk("t1_all", m_all, 0);
        chk("t1_ovf", m_overflow, 0);
        idle(1);

        beat(0, 0, 0); beat(0, 0, 0); beat(32'h0000_0010, 1, 0);
        chk("t2_count", m_count, 68);
        chk("t2_all", m_all, 0);

        beat(32'hFFFF_FFFF, 0, 1); beat(32'h0000_0007, 1, 0);
        chk("t3_count", m_count, 35);

        for (int i = 0; i < 18; i++) beat(0, i == 17, 0);
        chk("t4_count", m_count, 512);
        chk("t4_all", m_all, 1);
        chk("t4_ovf", m_overflow, 1);
        idle(1);

        m_ready = 0;
        beat(32'h0000_0004, 1, 0);
        s_valid = 1; s_data = 32'h8000_0000; s_last = 1; s_ones = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_stall", s_ready, 0);
            chk("t5_hold", m_count, 2);
        end
        @(posedge clk); #1;
        m_ready = 1;
        beat(32'h8000_0000, 1, 0);
        chk("t5_valid", m_valid, 1);
        chk("t5_count", m_count, 31);
        idle(1);

        beat(0, 0, 0); beat(0, 0, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("t6_valid", m_valid, 0);
        beat(32'h0000_0001, 1, 0);
        chk("t6_count", m_count, 0);
        chk("t6_ovf", m_overflow, 0);
`ifdef TZC_PKT_STATS_EN
        chk("t6_pkts", m_pkt_cnt, 1);
`endif

        rnd_rdy = 1;
        repeat (60) begin
            len = $urandom_range(1, 20);
            md = 1'($urandom % 2);
            for (int b = 0; b < len; b++) begin
                d = ($urandom | 32'h1) << $urandom_range(0, 31);
                if ($urandom % 4 < 2) d = '0;
                if (md) d = ~d;
                beat(d, b == len-1, (b == 0) ? md : 1'($urandom % 2));
                if ($urandom % 4 == 0) idle(1);
            end
        end
        rnd_rdy = 0;
        m_ready = 1;
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
